// File: rtl/mpe_uop_sequencer_if.sv
// mpe_uop_sequencer_if
//   Groups the command, PE uop/beat, memory-address, result and
//   output-buffer signals of the matrix-vector uop sequencer.
//   slave  : sequencer view (takes commands, drives uops/addresses/writes)
//   master : environment view (issues commands, models PE and buffers)
interface mpe_uop_sequencer_if;
    // command handshake
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_k;
    logic [7:0]  cmd_m;
    logic [9:0]  cmd_nbase;
    logic [11:0] cmd_wbase;
    logic [7:0]  cmd_obase;
    // PE uop port
    logic [7:0]  uop;
    logic        uop_valid;
    logic        uop_ready;
    logic        beat_ack;
    // NRAM / WRAM read addresses
    logic [9:0]  nram_addr;
    logic [11:0] wram_addr;
    // PE result stream
    logic        res_valid;
    logic [31:0] res_data;
    // output-buffer write port
    logic        out_wen;
    logic [7:0]  out_waddr;
    logic [31:0] out_wdata;
    // completion
    logic        done;
    logic        err;

    modport slave (
        input  cmd_valid, cmd_k, cmd_m, cmd_nbase, cmd_wbase, cmd_obase,
        input  uop_ready, beat_ack, res_valid, res_data,
        output cmd_ready, uop, uop_valid, nram_addr, wram_addr,
        output out_wen, out_waddr, out_wdata, done, err
    );

    modport master (
        output cmd_valid, cmd_k, cmd_m, cmd_nbase, cmd_wbase, cmd_obase,
        output uop_ready, beat_ack, res_valid, res_data,
        input  cmd_ready, uop, uop_valid, nram_addr, wram_addr,
        input  out_wen, out_waddr, out_wdata, done, err
    );
endinterface

// File: rtl/mpe_uop_sequencer.sv
// mpe_uop_sequencer
//   Sequences one matrix-vector command into M uops of K beats each toward
//   the matrix PE, generates NRAM/WRAM read addresses per beat, writes each
//   PE result to the output buffer and pulses done (with err for K=0/M=0).
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mpe_uop_sequencer_if.slave (command, uop, address, result,
//           output-buffer and done/err signals)
module mpe_uop_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    mpe_uop_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, FINISH} state_t;

    state_t      r_state;
    logic [7:0]  r_k, r_m, r_obase;
    logic [9:0]  r_nbase;
    logic [11:0] r_wbase;
    logic [7:0]  r_m_idx, r_k_idx, r_r_cnt;
    logic        r_cmd_ready, r_uop_valid, r_done, r_err, r_out_wen;
    logic [7:0]  r_uop, r_out_waddr;
    logic [31:0] r_out_wdata;

    logic [11:0] w_row_off;
    logic        w_last_row;
    logic        w_res;

    // Row offset into WRAM; 12-bit product so the address wraps mod 4096.
    assign w_row_off  = {4'd0, r_m_idx} * {4'd0, r_k};
    assign w_last_row = ({1'b0, r_m_idx} + 9'd1) >= {1'b0, r_m};
    // Results are accepted in every state except IDLE.
    assign w_res      = bus.res_valid && (r_state != IDLE);

    assign bus.nram_addr = r_nbase + {2'd0, r_k_idx};
    assign bus.wram_addr = r_wbase + w_row_off + {4'd0, r_k_idx};
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.uop       = r_uop;
    assign bus.uop_valid = r_uop_valid;
    assign bus.out_wen   = r_out_wen;
    assign bus.out_waddr = r_out_waddr;
    assign bus.out_wdata = r_out_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_m         <= '0;
            r_obase     <= '0;
            r_nbase     <= '0;
            r_wbase     <= '0;
            r_m_idx     <= '0;
            r_k_idx     <= '0;
            r_r_cnt     <= '0;
            r_cmd_ready <= 1'b1;
            r_uop_valid <= 1'b0;
            r_uop       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_wen   <= 1'b0;
            r_out_waddr <= '0;
            r_out_wdata <= '0;
        end else begin
            // Result path runs independently of the uop FSM so a result
            // coinciding with uop_ready is never lost.
            r_out_wen <= 1'b0;
            if (w_res) begin
                r_out_wen   <= 1'b1;
                r_out_waddr <= r_obase + r_r_cnt;
                r_out_wdata <= bus.res_data;
                r_r_cnt     <= r_r_cnt + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_k         <= bus.cmd_k;
                        r_m         <= bus.cmd_m;
                        r_nbase     <= bus.cmd_nbase;
                        r_wbase     <= bus.cmd_wbase;
                        r_obase     <= bus.cmd_obase;
                        r_m_idx     <= '0;
                        r_k_idx     <= '0;
                        r_r_cnt     <= '0;
                        r_cmd_ready <= 1'b0;
                        if (bus.cmd_k == 8'd0 || bus.cmd_m == 8'd0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_uop       <= bus.cmd_k;
                            r_uop_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // uop_valid low here is the mandatory one-cycle gap
                    // between consecutive uops.
                    if (!r_uop_valid) begin
                        r_uop_valid <= 1'b1;
                    end else if (bus.uop_ready) begin
                        r_uop_valid <= 1'b0;
                        r_k_idx     <= '0;
                        r_m_idx     <= r_m_idx + 8'd1;
                        if (w_last_row)
                            r_state <= WAIT_RES;
                    end else if (bus.beat_ack) begin
                        r_k_idx <= r_k_idx + 8'd1;
                    end
                end
                WAIT_RES: begin
                    if (r_r_cnt == r_m) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end
                end
                FINISH: begin
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpe_uop_sequencer.sv
module tb_mpe_uop_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mpe_uop_sequencer_if bus();

    mpe_uop_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One command end-to-end with a PE/result model. Expected beat addresses
    // and buffer writes come from the address formulas directly.
    task automatic run_cmd(input int k, input int m, input int nb, input int wb,
                           input int ob, input int ack_pct, input int res_dly,
                           input int last_dly, input int abort_row,
                           output bit aborted);
        int exp_n[$], exp_w[$], exp_a[$], exp_d[$], due[$];
        int busy = 0, beats_left = 0, rows_done = 0, uops = 0, gap = 0;
        int cyc = 0, wen_seen = 0, uv_seen = 0, res_sent = 0, en, ew;
        bit fin = 0;
        logic [31:0] d;
        aborted = 0;
        for (int r = 0; r < m; r++)
            for (int kk = 0; kk < k; kk++) begin
                exp_n.push_back((nb + kk) % 1024);
                exp_w.push_back((wb + r * k + kk) % 4096);
            end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle: got %b want 1", bus.cmd_ready);
        end
        bus.cmd_k = 8'(k); bus.cmd_m = 8'(m); bus.cmd_nbase = 10'(nb);
        bus.cmd_wbase = 12'(wb); bus.cmd_obase = 8'(ob); bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (!fin) begin
            cyc++;
            bus.beat_ack = 1'b0; bus.uop_ready = 1'b0; bus.res_valid = 1'b0;
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
                errors++; $display("FAIL cmd_ready_busy: cyc %0d got %b want 0", cyc, bus.cmd_ready);
            end
            if (bus.out_wen === 1'b1) begin
                wen_seen++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL extra_write: addr %h", bus.out_waddr);
                end else begin
                    en = exp_a.pop_front(); ew = exp_d.pop_front();
                    if (bus.out_waddr !== 8'(en) || bus.out_wdata !== 32'(ew)) begin
                        errors++; $display("FAIL write: got %h/%h want %h/%h",
                                           bus.out_waddr, bus.out_wdata, 8'(en), 32'(ew));
                    end
                end
            end
            if (bus.done === 1'b1) begin
                fin = 1;
                checks++;
                if (k == 0 || m == 0) begin
                    if (bus.err !== 1'b1 || cyc != 1 || uv_seen != 0 || wen_seen != 0) begin
                        errors++; $display("FAIL done_err: err %b cyc %0d uv %0d wen %0d want 1/1/0/0",
                                           bus.err, cyc, uv_seen, wen_seen);
                    end
                end else if (bus.err !== 1'b0 || wen_seen != m || uops != m || exp_n.size() != 0) begin
                    errors++; $display("FAIL done_ok: err %b writes %0d uops %0d left %0d want 0/%0d/%0d/0",
                                       bus.err, wen_seen, uops, exp_n.size(), m, m);
                end
            end
            if (bus.uop_valid === 1'b1) begin
                uv_seen++;
                if (!busy) begin
                    checks++;
                    if ((rows_done > 0 && gap != 1) || bus.uop !== 8'(k)) begin
                        errors++; $display("FAIL uop_issue: gap %0d uop %0d want 1/%0d", gap, bus.uop, k);
                    end
                    if (abort_row >= 0 && rows_done == abort_row) begin
                        aborted = 1;
                        return;
                    end
                    busy = 1; beats_left = k; uops++;
                end
                if (int'($urandom_range(0, 99)) < ack_pct) begin
                    bus.beat_ack = 1'b1;
                    checks++;
                    if (exp_n.size() == 0) begin
                        errors++; $display("FAIL extra_beat: nram %h", bus.nram_addr);
                    end else begin
                        en = exp_n.pop_front(); ew = exp_w.pop_front();
                        if (bus.nram_addr !== 10'(en) || bus.wram_addr !== 12'(ew)) begin
                            errors++; $display("FAIL beat_addr: got %h/%h want %h/%h",
                                               bus.nram_addr, bus.wram_addr, 10'(en), 12'(ew));
                        end
                    end
                    beats_left--;
                    if (beats_left == 0) begin
                        bus.uop_ready = 1'b1;
                        busy = 0; rows_done++; gap = 0;
                        due.push_back(cyc + ((rows_done == m) ? last_dly : res_dly));
                    end
                end
            end else if (rows_done > 0) begin
                gap++;
            end
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                d = $urandom;
                bus.res_valid = 1'b1; bus.res_data = d;
                exp_a.push_back((ob + res_sent) % 256); exp_d.push_back(int'(d));
                res_sent++;
            end
            if (cyc > 3000) begin
                errors++; $display("FAIL timeout: no done after %0d cycles", cyc);
                fin = 1;
            end
            @(negedge clk);
        end
        bus.beat_ack = 1'b0; bus.uop_ready = 1'b0; bus.res_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++; $display("FAIL after_done: done %b ready %b err %b want 0/1/0",
                               bus.done, bus.cmd_ready, bus.err);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.uop_valid !== 1'b0 || bus.out_wen !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0 || bus.uop !== 8'd0 ||
            bus.nram_addr !== 10'd0 || bus.wram_addr !== 12'd0 ||
            bus.out_waddr !== 8'd0 || bus.out_wdata !== 32'd0) begin
            errors++;
            $display("FAIL %s: rdy %b uv %b wen %b done %b err %b uop %h n %h w %h oa %h od %h want reset values",
                     tag, bus.cmd_ready, bus.uop_valid, bus.out_wen, bus.done, bus.err, bus.uop,
                     bus.nram_addr, bus.wram_addr, bus.out_waddr, bus.out_wdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset_idle");
    endtask

    task automatic test_basic();
        bit a;
        run_cmd(4, 2, 'h10, 'h100, 'h20, 100, 0, 0, -1, a);
    endtask

    task automatic test_back_to_back();
        bit a;
        run_cmd(1, 3, 'h3, 'h40, 'h7, 100, 0, 0, -1, a);
    endtask

    task automatic test_zero();
        bit a;
        run_cmd(0, 5, 'h1, 'h2, 'h3, 100, 0, 0, -1, a);
        run_cmd(3, 0, 'h1, 'h2, 'h3, 100, 0, 0, -1, a);
    endtask

    task automatic test_late_result();
        bit a;
        run_cmd(2, 2, 'h3F0, 'h200, 'hFE, 100, 0, 10, -1, a);
    endtask

    task automatic test_wram_wrap();
        bit a;
        run_cmd(3, 1, 'h3FE, 'hFFE, 'h0, 100, 0, 0, -1, a);
    endtask

    task automatic test_idle_ignore();
        logic [9:0] n0;
        n0 = bus.nram_addr;
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1; bus.beat_ack = 1'b1; bus.res_data = $urandom;
            @(negedge clk);
            checks++;
            if (bus.out_wen !== 1'b0 || bus.nram_addr !== n0 || bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL idle_ignore: wen %b nram %h ready %b want 0/%h/1",
                                   bus.out_wen, bus.nram_addr, bus.cmd_ready, n0);
            end
        end
        bus.res_valid = 1'b0; bus.beat_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit a;
        run_cmd(3, 4, 'h55, 'h321, 'h44, 100, 0, 0, 1, a);
        checks++;
        if (!a) begin
            errors++; $display("FAIL mid_abort_reached: got %b want 1", a);
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(2, 1, 'h7, 'h9, 'h11, 100, 0, 0, -1, a);
    endtask

    task automatic test_random();
        bit a;
        for (int i = 0; i < 12; i++)
            run_cmd(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 255)), int'($urandom_range(30, 100)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), -1, a);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_k = '0; bus.cmd_m = '0; bus.cmd_nbase = '0;
        bus.cmd_wbase = '0; bus.cmd_obase = '0; bus.uop_ready = 1'b0; bus.beat_ack = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero();
        test_late_result();
        test_wram_wrap();
        test_idle_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpe_uop_sequencer.md
MPE_UOP_SEQUENCER -- requirements
Module: mpe_uop_sequencer

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 cmd_valid / cmd_ready  input / output  1 / 1  matrix-vector command handshake; accepted on the cycle both are high.
REQ-004 cmd_k  input  8  512-bit chunks per dot product (K).
REQ-005 cmd_m  input  8  number of output rows (M).
REQ-006 cmd_nbase / cmd_wbase / cmd_obase  input  10 / 12 / 8  NRAM, WRAM and output-buffer base addresses.
REQ-007 uop / uop_valid  output  8 / 1  iteration count and valid toward the matrix PE uop port.
REQ-008 uop_ready  input  1  one-cycle pulse from the PE when the in-flight uop completes its last beat.
REQ-009 beat_ack  input  1  high on each cycle the PE consumes one neuron/weight beat.
REQ-010 nram_addr / wram_addr  output  10 / 12  current read addresses presented to the NRAM/WRAM wrappers.
REQ-011 res_valid / res_data  input  1 / 32  PE result stream.
REQ-012 out_wen / out_waddr / out_wdata  output  1 / 8 / 32  output-buffer write port.
REQ-013 done / err  output  1 / 1  one-cycle completion pulse; err qualifies done.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_RES and FINISH.
REQ-015 IDLE: cmd_ready=1; on accept, latch K, M and the three bases, clear row index m_idx, beat index k_idx and result count r_cnt.
REQ-016 On accept with K=0 or M=0, go to FINISH with err=1; no uop issued and no write performed.
REQ-017 Otherwise go to ISSUE with uop=K and uop_valid=1 from the next cycle.
REQ-018 ISSUE: uop_valid SHALL stay high and uop stable until uop_ready is sampled high; uop_valid SHALL go low in the cycle after that edge, for at least one cycle.
REQ-019 At most one uop SHALL be in flight.
REQ-020 Addresses: nram_addr = nbase + k_idx; wram_addr = wbase + m_idx*K + k_idx, computed in 12 bits with modulo-2^12 wrap.
REQ-021 Each beat_ack SHALL increment k_idx.
REQ-022 k_idx SHALL clear when uop_ready is sampled.
REQ-023 beat_ack outside ISSUE SHALL be ignored.
REQ-024 On uop_ready, m_idx SHALL increment.
REQ-025 On uop_ready, if m_idx+1 < M, re-assert uop_valid with the same K after the one-cycle gap; otherwise go to WAIT_RES.
REQ-026 Each res_valid, in any non-IDLE state, SHALL produce out_wen=1 in the next cycle, with out_waddr = obase + r_cnt (mod 256) and out_wdata = res_data; r_cnt then increments.
REQ-027 res_valid in IDLE SHALL be dropped.
REQ-028 A res_valid in the same cycle as uop_ready SHALL be handled with no loss.
REQ-029 WAIT_RES: when r_cnt equals M, including the case where this is already true on entry, go to FINISH.
REQ-030 FINISH: done=1 for exactly one cycle, err as set, then return to IDLE.
REQ-031 cmd_ready SHALL be 0 in every state except IDLE.

Reset
REQ-032 Reset SHALL force IDLE, cmd_ready=1, and uop_valid, out_wen, done and err to 0.
REQ-033 Reset SHALL clear uop, nram_addr, wram_addr, out_waddr, out_wdata and all counters to 0.
REQ-034 Reset mid-command SHALL abandon it; the first command after reset SHALL behave as from power-up.

Verification
REQ-035 K=4, M=2, nbase=0x10, wbase=0x100, obase=0x20, PE model acking every cycle -> nram_addr 0x10..0x13 twice; wram_addr 0x100..0x103 then 0x104..0x107; two uops of 4; out_waddr 0x20,0x21; one done, err=0.
REQ-036 K=1, M=3, with uop_ready on the beat after each issue -> uop_valid low for exactly one cycle between uops; three writes; done after the third result.
REQ-037 K=0, M=5 -> done and err high together one cycle after accept; uop_valid and out_wen never asserted.
REQ-038 M=2 with last result delayed 10 cycles after the final uop_ready -> stays in WAIT_RES with cmd_ready=0 until the write, then done.
REQ-039 wbase=0xFFE, K=3, M=1 -> wram_addr 0xFFE, 0xFFF, 0x000.
REQ-040 rst_n low during ISSUE of row 1 of M=4 -> all outputs at reset values immediately; a new K=2, M=1 command then completes normally.
